// File: rtl/data_path.sv
// Datapath slave of the watch-mode controller: step register s, value register y,
// and the registered status flags returned to the control automaton.
module data_path #(
  parameter int S_W   = 3,
  parameter int S_MOD = 4,
  parameter int Y_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Y_W-1:0] x,
  input  logic           s_en,
  input  logic           s_add,
  input  logic [1:0]     s_step,
  input  logic           s_zero,
  input  logic           y_en,
  input  logic           y_store_x,
  input  logic [1:0]     y_select_next,
  output logic           y_inc,
  output logic [S_W-1:0] s,
  output logic [Y_W-1:0] y,
  output logic           y_upd,
  output logic           y_ovf
);

  typedef enum logic [1:0] {
    Y_HOLD = 2'd0,
    Y_INCR = 2'd1,
    Y_DECR = 2'd2,
    Y_CLR  = 2'd3
  } y_op_e;

  localparam logic [S_W:0] MOD_EXT = (S_W+1)'(S_MOD);

  logic [S_W-1:0] base;
  logic [S_W:0]   sum;
  logic [S_W-1:0] s_next;
  logic           inc_next;
  logic [Y_W-1:0] y_next;
  logic           ovf_next;
  y_op_e          y_op;

  assign y_op = y_op_e'(y_select_next);

  // Add is evaluated one bit wider so the wrap against S_MOD is detected before
  // truncation; only a single subtraction is applied, even when base >= S_MOD.
  always_comb begin
    base     = s_zero ? '0 : s;
    sum      = {1'b0, base} + (S_W+1)'(s_step);
    s_next   = s;
    inc_next = 1'b0;
    if (s_en) begin
      if (s_add) begin
        if (sum >= MOD_EXT) begin
          s_next   = S_W'(sum - MOD_EXT);
          inc_next = 1'b1;
        end else begin
          s_next = sum[S_W-1:0];
        end
      end else begin
        s_next = base - S_W'(s_step);
      end
    end
  end

  always_comb begin
    y_next   = y;
    ovf_next = y_ovf;
    if (y_en) begin
      if (y_store_x) begin
        y_next   = x;
        ovf_next = 1'b0;
      end else begin
        unique case (y_op)
          Y_INCR: begin
            y_next = y + 1'b1;
            if (y == '1) ovf_next = 1'b1;
          end
          Y_DECR: begin
            y_next = y - 1'b1;
            if (y == '0) ovf_next = 1'b1;
          end
          Y_CLR:   y_next = '0;
          default: y_next = y;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= '0;
      y     <= '0;
      y_inc <= 1'b0;
      y_upd <= 1'b0;
      y_ovf <= 1'b0;
    end else begin
      s     <= s_next;
      y     <= y_next;
      y_inc <= inc_next;
      y_upd <= (y_next != y);
      y_ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus randomized commands
// compared against an integer reference model.
module tb_data_path;
  localparam int S_W   = 3;
  localparam int S_MOD = 4;
  localparam int Y_W   = 4;
  localparam int S_RNG = 1 << S_W;
  localparam int Y_RNG = 1 << Y_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [Y_W-1:0] x = '0;
  logic           s_en = 1'b0, s_add = 1'b0, s_zero = 1'b0;
  logic [1:0]     s_step = '0;
  logic           y_en = 1'b0, y_store_x = 1'b0;
  logic [1:0]     y_select_next = '0;
  logic           y_inc, y_upd, y_ovf;
  logic [S_W-1:0] s;
  logic [Y_W-1:0] y;

  int checks = 0;
  int failures = 0;
  int m_s = 0, m_y = 0, m_inc = 0, m_upd = 0, m_ovf = 0;
  int upd_cnt = 0;

  data_path #(.S_W(S_W), .S_MOD(S_MOD), .Y_W(Y_W)) dut (
    .clk(clk), .rst(rst), .x(x), .s_en(s_en), .s_add(s_add), .s_step(s_step),
    .s_zero(s_zero), .y_en(y_en), .y_store_x(y_store_x),
    .y_select_next(y_select_next), .y_inc(y_inc), .s(s), .y(y),
    .y_upd(y_upd), .y_ovf(y_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: applies the command rules to plain integers.
  task automatic model_step();
    int b, sum, prev;
    if (rst) begin
      m_s = 0; m_y = 0; m_inc = 0; m_upd = 0; m_ovf = 0;
      return;
    end
    b = s_zero ? 0 : m_s;
    m_inc = 0;
    if (s_en) begin
      if (s_add) begin
        sum = b + int'(s_step);
        if (sum >= S_MOD) begin
          m_s = (sum - S_MOD) % S_RNG;
          m_inc = 1;
        end else m_s = sum;
      end else begin
        m_s = (b - int'(s_step) + S_RNG) % S_RNG;
      end
    end
    prev = m_y;
    if (y_en) begin
      if (y_store_x) begin
        m_y = int'(x);
        m_ovf = 0;
      end else if (y_select_next == 2'd1) begin
        m_y = (prev + 1) % Y_RNG;
        if (prev == Y_RNG - 1) m_ovf = 1;
      end else if (y_select_next == 2'd2) begin
        m_y = (prev + Y_RNG - 1) % Y_RNG;
        if (prev == 0) m_ovf = 1;
      end else if (y_select_next == 2'd3) begin
        m_y = 0;
      end
    end
    m_upd = (m_y != prev) ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (y_upd) upd_cnt++;
    check("s", int'(s), m_s);
    check("y", int'(y), m_y);
    check("y_inc", int'(y_inc), m_inc);
    check("y_upd", int'(y_upd), m_upd);
    check("y_ovf", int'(y_ovf), m_ovf);
  endtask

  task automatic idle();
    s_en = 0; s_add = 0; s_step = 0; s_zero = 0;
    y_en = 0; y_store_x = 0; y_select_next = 0; rst = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    int exp_cd[4] = '{6, 4, 2, 0};
    int exp_cc[5] = '{1, 2, 3, 0, 1};
    logic loop_inc;

    do_reset();
    check("rst_s", int'(s), 0);
    check("rst_y", int'(y), 0);

    // Countdown
    idle(); s_en = 1; s_zero = 1; s_add = 0; s_step = 2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cd_s", int'(s), exp_cd[i]);
      check("cd_inc", int'(y_inc), 0);
      s_zero = 0;
    end

    // Count with carry
    do_reset();
    s_en = 1; s_add = 1; s_step = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cc_s", int'(s), exp_cc[i]);
      check("cc_inc", int'(y_inc), (i == 3) ? 1 : 0);
    end

    // Closed loop: increment y the cycle after each carry
    do_reset();
    upd_cnt = 0;
    loop_inc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_en = (i < 8); s_add = 1; s_step = 1;
      y_en = loop_inc; y_select_next = 2'd1;
      tick();
      loop_inc = y_inc;
    end
    idle(); tick();
    check("loop_y", int'(y), 2);
    check("loop_upd_pulses", upd_cnt, 2);

    // Update sequence
    do_reset();
    x = 4'd9; y_en = 1; y_store_x = 1; tick();
    check("seq_y_load", int'(y), 9);
    check("seq_upd_load", int'(y_upd), 1);
    y_store_x = 0; y_select_next = 2'd2; tick();
    check("seq_y_dec", int'(y), 8);
    check("seq_upd_dec", int'(y_upd), 1);
    idle(); s_en = 1; s_add = 0; s_step = 1; tick();
    check("seq_s", int'(s), 7);
    check("seq_upd_idle", int'(y_upd), 0);

    // Overflow
    idle(); x = 4'd15; y_en = 1; y_store_x = 1; tick();
    y_store_x = 0; y_select_next = 2'd1; tick();
    check("ovf_y_inc", int'(y), 0);
    check("ovf_flag_inc", int'(y_ovf), 1);
    y_select_next = 2'd2; tick();
    check("ovf_y_dec", int'(y), 15);
    check("ovf_flag_dec", int'(y_ovf), 1);
    x = 4'd3; y_store_x = 1; tick();
    check("ovf_clear", int'(y_ovf), 0);
    x = 4'd3; tick();
    check("store_equal_no_upd", int'(y_upd), 0);

    // Add entered with s >= S_MOD: single subtraction
    idle(); s_en = 1; s_zero = 1; s_step = 1; tick();
    s_zero = 0; s_add = 1; s_step = 3; tick();
    check("big_s", int'(s), 6);
    check("big_inc", int'(y_inc), 1);

    // Reset mid-operation
    do_reset();
    x = 4'd5; y_en = 1; y_store_x = 1;
    s_en = 1; s_add = 1; s_step = 1; tick();
    y_en = 0; tick();
    check("mid_s", int'(s), 2);
    check("mid_y", int'(y), 5);
    rst = 1; tick();
    check("mid_rst_s", int'(s), 0);
    check("mid_rst_y", int'(y), 0);
    rst = 0; tick();
    check("mid_resume_s", int'(s), 1);

    // Randomized commands
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      x = Y_W'($urandom);
      s_en = $urandom_range(0, 1) == 1;
      s_add = $urandom_range(0, 1) == 1;
      s_step = 2'($urandom);
      s_zero = ($urandom_range(0, 3) == 0);
      y_en = $urandom_range(0, 1) == 1;
      y_store_x = ($urandom_range(0, 4) == 0);
      y_select_next = 2'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_path.md
# data_path

Datapath slave of the watch-mode controller: owns the step register `s` and value register `y` and executes the per-cycle command word (`s_en/s_add/s_step/s_zero`, `y_en/y_store_x/y_select_next`) issued by the control automaton. It returns the carry indication `y_inc` that the controller samples to decide on `y` increments. All state and outputs are registered, so the controller always sees a stable view one cycle after each command.

## Interface
Parameters:
- `S_W`, 3, width of `s`; arithmetic is modulo 2^S_W unless stated otherwise.
- `S_MOD`, 4, count modulus for add mode; legal range 2..2^S_W.
- `Y_W`, 4, width of `y` and `x`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `x`  in  Y_W  load value for `y`.
- `s_en`  in  1  update `s` this cycle.
- `s_add`  in  1  1 = add (modulo S_MOD), 0 = subtract (modulo 2^S_W).
- `s_step`  in  2  step operand, 0..3.
- `s_zero`  in  1  use 0 instead of `s` as the operand base.
- `y_en`  in  1  update `y` this cycle.
- `y_store_x`  in  1  load `x` into `y`; overrides `y_select_next`.
- `y_select_next`  in  2  0 hold, 1 increment, 2 decrement, 3 clear.
- `y_inc`  out  1  registered carry: last `s` add wrapped past S_MOD.
- `s`  out  S_W  step register.
- `y`  out  Y_W  value register.
- `y_upd`  out  1  one-cycle pulse: `y` changed value on the previous edge.
- `y_ovf`  out  1  sticky: `y` wrapped on increment or decrement.

## Operation
- Base: `b = s_zero ? 0 : s`.
- `s_en=1, s_add=1`: `sum = b + s_step` computed in S_W+1 bits. If `sum >= S_MOD`, then `s <= sum - S_MOD` (single subtraction) and `y_inc <= 1`. Otherwise `s <= sum` and `y_inc <= 0`.
- `s_en=1, s_add=0`: `s <= (b - s_step) mod 2^S_W`, `y_inc <= 0`. Example: `s_zero=1, s_step=2` gives `s=6` when S_W=3.
- `s_en=0`: `s` holds, `y_inc <= 0`. `y_inc` is therefore a single-cycle pulse per wrapping add.
- `y_en=1`:
  - `y_store_x=1`: `y <= x` and `y_ovf <= 0` (a load clears the overflow flag).
  - Else `y_select_next=1`: `y <= y+1` mod 2^Y_W. `y_ovf <= 1` if `y` was all-ones.
  - Else `y_select_next=2`: `y <= y-1` mod 2^Y_W. `y_ovf <= 1` if `y` was 0.
  - Else `y_select_next=3`: `y <= 0`. `y_ovf` holds.
  - Else (`y_select_next=0`): hold.
- `y_en=0`: `y` and `y_ovf` hold.
- `y_upd <= 1` exactly when the next `y` differs from the current `y`; otherwise 0. A store of an equal value, or a clear of 0, gives no pulse.
- `s` and `y` commands are independent and may occur in the same cycle.

## Timing
- Reset (`rst=1` at an edge): `s=0`, `y=0`, `y_inc=0`, `y_upd=0`, `y_ovf=0`. Reset overrides any command in that cycle, including mid-sequence.
- Every output reflects the command present at the preceding edge; latency is 1 cycle with no combinational input-to-output path.
- Controller loop: a wrapping add at edge N gives `y_inc=1` after N. The controller samples it and issues the `y` increment at edge N+1, so `y` changes after N+1 and `y_upd` is high for the following cycle.
- Held commands repeat every cycle. Example: `s_en=1, s_add=0, s_step=2` held for three cycles gives 6→4→2→0.
- If `s >= S_MOD` on entry to add mode (e.g. 6 left over from a countdown), a single subtraction of S_MOD is applied. The result may still be ≥ S_MOD; this is legal and defined.
- `s_step=0` with `s_en=1`: `s` is reloaded with `b`, so `s_zero=1` clears it.

## Test plan
- Countdown: cycle 1 `s_en=1, s_zero=1, s_add=0, s_step=2`, then the same with `s_zero=0` for 3 cycles → `s` = 6, 4, 2, 0 on successive cycles; `y_inc` stays 0.
- Count/carry (S_MOD=4): from `s=0`, hold `s_en=1, s_add=1, s_step=1` → `s` = 1, 2, 3, 0, 1. `y_inc` is 1 only in the cycle `s` shows 0.
- Closed loop: drive `y_en=1, y_select_next=1` the cycle after each `y_inc` pulse, for 8 adds → `y=2`, with exactly 2 `y_upd` pulses.
- Update sequence: `x=9`, `y_en=1, y_store_x=1`, then `y_select_next=2`, then `s_en=1, s_add=0, s_step=1` from `s=0` → `y` = 9, then 8 (`y_upd` pulse each time), `s=7`.
- Overflow: load `x=15`, increment → `y=0`, `y_ovf=1`. Decrement → `y=15`, `y_ovf` stays 1. Load `x=3` → `y_ovf=0`.
- Reset mid-operation: assert `rst` during a held count with `s=2, y=5` → next cycle all outputs 0. Commands resume from `s=0` after `rst` drops.
